// File: rtl/gpio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised input level, per-bit sticky edge capture
// and a maskable level interrupt, on a 4-word register map.
module gpio_in_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // stage: synchronizer chain and edge-delay register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= data_in;
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      0:       edges = data_in & ~prev;
      1:       edges = ~data_in & prev;
      default: edges = data_in ^ prev;
    endcase
  end

  assign clear = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // stage: control registers; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clear) | edges;
    end
  end

  assign irq = |(edgecapture & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(data_in);
      2'd2:    readdata = 32'(irqmask);
      2'd3:    readdata = 32'(edgecapture);
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_in_edge_capture.sv
// Bench for gpio_in_edge_capture: rising, falling and any-edge builds driven in
// parallel and compared against a history-queue reference model.
module tb_gpio_in_edge_capture;
  localparam int W  = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [W-1:0]      in_port;
  logic [2:0][31:0]  rd;
  logic [2:0]        irqv;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] m_ec [3];
  logic [W-1:0] m_mask;

  gpio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irqv[0]));
  gpio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irqv[1]));
  gpio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irqv[2]));

  function automatic logic [W-1:0] edge_of(int et, logic [W-1:0] d, logic [W-1:0] p);
    if (et == 0) return d & ~p;
    if (et == 1) return ~d & p;
    return d ^ p;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back('0);
    for (int et = 0; et < 3; et++) m_ec[et] = '0;
    m_mask = '0;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; the model samples what the bench drove before the edge.
  task automatic step();
    logic [W-1:0] d, p, clr;
    bit wr;
    d   = hist[SS-1];
    p   = hist[SS];
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    @(posedge clk);
    if (reset_n) begin
      for (int et = 0; et < 3; et++) m_ec[et] = (m_ec[et] & ~clr) | edge_of(et, d, p);
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_front(in_port);
      void'(hist.pop_back());
    end
    #1;
    write_n = 1'b1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_reg(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
  endtask

  task automatic rdchk(string tag, logic [1:0] a, int et, logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, rd[et], exp);
  endtask

  task automatic check_all(string tag);
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a); chipselect = 1'b1; write_n = 1'b1;
      #1;
      for (int et = 0; et < 3; et++) begin
        case (a)
          0:       exp = 32'(hist[SS-1]);
          2:       exp = 32'(m_mask);
          3:       exp = 32'(m_ec[et]);
          default: exp = 32'h0;
        endcase
        chk($sformatf("%s_a%0d_e%0d", tag, a, et), rd[et], exp);
      end
    end
    for (int et = 0; et < 3; et++)
      chk($sformatf("%s_irq_e%0d", tag, et), 32'(irqv[et]), 32'(|(m_ec[et] & m_mask)));
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    steps(2);
    check_all("rst_hold");
    reset_n = 1'b1;
    check_all("rst_rel");

    // input latency: sample at k, DATA at k+1, capture at k+2
    in_port = 8'hA5;
    step();
    rdchk("a5_data_k", 2'd0, 0, 32'h0);
    check_all("a5_k");
    step();
    rdchk("a5_data_k1", 2'd0, 0, 32'hA5);
    rdchk("a5_ec_k1", 2'd3, 0, 32'h0);
    check_all("a5_k1");
    step();
    rdchk("a5_ec_k2_r", 2'd3, 0, 32'hA5);
    rdchk("a5_ec_k2_f", 2'd3, 1, 32'h0);
    rdchk("a5_ec_k2_a", 2'd3, 2, 32'hA5);
    check_all("a5_k2");

    // masked interrupt and clear
    in_port = 8'h00;
    steps(3);
    wr_reg(2'd3, 32'hFFFF_FFFF);
    check_all("clr_all");
    wr_reg(2'd2, 32'h0000_0001);
    in_port = 8'h01;
    steps(2);
    chk("irq_k1", 32'(irqv[0]), 32'h0);
    step();
    chk("irq_k2", 32'(irqv[0]), 32'h1);
    rdchk("irq_ec", 2'd3, 0, 32'h1);
    check_all("irq_set");
    wr_reg(2'd3, 32'h0000_0001);
    chk("irq_clr", 32'(irqv[0]), 32'h0);
    rdchk("ec_clr", 2'd3, 0, 32'h0);
    check_all("irq_cleared");

    // clear in the same cycle the edge is detected
    in_port = 8'h00;
    steps(3);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h01;
    steps(2);
    wr_reg(2'd3, 32'h0000_0001);
    rdchk("simul_ec", 2'd3, 0, 32'h1);
    chk("simul_irq", 32'(irqv[0]), 32'h1);
    check_all("simul");
    wr_reg(2'd2, 32'h0);
    chk("mask_off_irq", 32'(irqv[0]), 32'h0);
    check_all("mask_off");

    // falling / any edge builds
    in_port = 8'h00;
    steps(3);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'hFF;
    steps(3);
    rdchk("rise_r", 2'd3, 0, 32'hFF);
    rdchk("rise_f", 2'd3, 1, 32'h00);
    rdchk("rise_a", 2'd3, 2, 32'hFF);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h0F;
    steps(3);
    rdchk("fall_r", 2'd3, 0, 32'h00);
    rdchk("fall_f", 2'd3, 1, 32'hF0);
    rdchk("fall_a", 2'd3, 2, 32'hF0);
    check_all("fall");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(3) == 0) in_port = W'($urandom);
      r = $urandom_range(7);
      if (r == 0)      wr_reg(2'd2, $urandom);
      else if (r == 1) wr_reg(2'd3, $urandom);
      else if (r == 2) wr_reg(2'($urandom_range(1)), $urandom);
      else             step();
      check_all($sformatf("rnd%0d", n));
    end

    // asynchronous reset mid-operation, then release with inputs high
    wr_reg(2'd2, 32'hFF);
    in_port = 8'h00;
    steps(3);
    in_port = 8'hFF;
    steps(3);
    chk("pre_rst_irq", 32'(irqv[0]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_irq", 32'(irqv[0]), 32'h0);
    rdchk("async_data", 2'd0, 0, 32'h0);
    rdchk("async_mask", 2'd2, 0, 32'h0);
    rdchk("async_ec", 2'd3, 2, 32'h0);
    steps(2);
    check_all("rst_mid");
    reset_n = 1'b1;
    step();
    check_all("rel1");
    step();
    rdchk("rel2_ec", 2'd3, 0, 32'h0);
    check_all("rel2");
    step();
    rdchk("rel3_ec_r", 2'd3, 0, 32'hFF);
    rdchk("rel3_ec_f", 2'd3, 1, 32'h00);
    rdchk("rel3_ec_a", 2'd3, 2, 32'hFF);
    check_all("rel3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
